serial_chunk_adder: RTL and testbench

SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

---
 rtl/serial_chunk_adder_if.sv | 26 ++
 rtl/serial_chunk_adder.sv | 102 ++++++++++
 tb/tb_serial_chunk_adder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_chunk_adder_if.sv
// Operand/result bundle for serial_chunk_adder: request fields from the
// master, result and status flags back from the adder.
interface serial_chunk_adder_if #(
    parameter int WIDTH = 12
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, cin, sub,
        input  s, cout, ovf, busy, done
    );

    modport slave (
        input  start, a, b, cin, sub,
        output s, cout, ovf, busy, done
    );
endinterface

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, LSB slice first,
// with a registered carry linking the slices.
module serial_chunk_adder #(
    parameter int WIDTH = 12,
    parameter int CHUNK = 4
) (
    input logic                 clk,
    input logic                 rst,
    serial_chunk_adder_if.slave bus
);
    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             carry_q;
    logic [IDXW-1:0]  idx_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic [CHUNK:0]   sum_d;
    logic             ovf_d;

    function automatic logic [CHUNK:0] slice_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
    endfunction

    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    function automatic logic signed_ovf(input logic x_msb, input logic y_msb,
                                        input logic sum_msb, input logic co);
        return (x_msb ^ y_msb ^ sum_msb) ^ co;
    endfunction

    always_comb begin
        sum_d = slice_add(a_q[CHUNK-1:0], b_q[CHUNK-1:0], carry_q);
        ovf_d = signed_ovf(a_q[CHUNK-1], b_q[CHUNK-1], sum_d[CHUNK-1], sum_d[CHUNK]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        // Subtraction folds into addition of ~b and ~cin.
                        a_q     <= bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.cin ^ bus.sub;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (int'(idx_q) == i) s_q[i*CHUNK +: CHUNK] <= sum_d[CHUNK-1:0];
                    end
                    carry_q <= sum_d[CHUNK];
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    idx_q   <= idx_q + IDXW'(1);
                    if (idx_q == LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cout_q  <= sum_d[CHUNK];
                        ovf_q   <= ovf_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_serial_chunk_adder.sv
// Bench for serial_chunk_adder: three instances (CHUNK = 4, 12, 1) checked
// against an integer-arithmetic reference model.
module tb_serial_chunk_adder;
    localparam int W = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic         start_v[3];
    logic [W-1:0] a_v[3];
    logic [W-1:0] b_v[3];
    logic         cin_v[3];
    logic         sub_v[3];
    logic [W-1:0] s_v[3];
    logic         cout_v[3];
    logic         ovf_v[3];
    logic         busy_v[3];
    logic         done_v[3];
    logic         prev_cout[3];
    logic         prev_ovf[3];

    int nslc[3]  = '{3, 1, 12};
    int chunk[3] = '{4, 12, 1};

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        serial_chunk_adder_if #(.WIDTH(W)) bus ();
        assign bus.start = start_v[g];
        assign bus.a     = a_v[g];
        assign bus.b     = b_v[g];
        assign bus.cin   = cin_v[g];
        assign bus.sub   = sub_v[g];
        assign s_v[g]    = bus.s;
        assign cout_v[g] = bus.cout;
        assign ovf_v[g]  = bus.ovf;
        assign busy_v[g] = bus.busy;
        assign done_v[g] = bus.done;

        serial_chunk_adder #(
            .WIDTH(W),
            .CHUNK(g == 0 ? 4 : (g == 1 ? 12 : 1))
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    task automatic chk(input string tag, input int sel,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, sel, obs, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on the operands.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub,
                                  output logic [W-1:0] s, output logic co,
                                  output logic ov);
        int ua, ub, sa, sb, full, r;
        ua = int'(a);
        ub = int'(b);
        sa = a[W-1] ? ua - (1 << W) : ua;
        sb = b[W-1] ? ub - (1 << W) : ub;
        if (!sub) begin
            full = ua + ub + int'(cin);
            co   = (full >= (1 << W));
            r    = sa + sb + int'(cin);
        end else begin
            full = ua - ub - int'(cin);
            co   = (full >= 0);
            r    = sa - sb - int'(cin);
        end
        s  = full[W-1:0];
        ov = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
    endfunction

    task automatic scramble(input int sel);
        a_v[sel]   = W'($urandom);
        b_v[sel]   = W'($urandom);
        cin_v[sel] = 1'($urandom);
        sub_v[sel] = 1'($urandom);
    endtask

    // Called just after a falling edge with the target instance in IDLE or DONE.
    task automatic run_op(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input bit mid_start, input bit idle_after);
        logic [W-1:0] es;
        logic         ec, eo;
        logic [31:0]  mask;
        model(a, b, cin, sub, es, ec, eo);
        start_v[sel] = 1'b1;
        a_v[sel]     = a;
        b_v[sel]     = b;
        cin_v[sel]   = cin;
        sub_v[sel]   = sub;
        @(posedge clk);
        #1;
        start_v[sel] = 1'b0;
        scramble(sel);
        for (int i = 1; i <= nslc[sel]; i++) begin
            @(negedge clk);
            chk("busy_run", sel, 32'(busy_v[sel]), 32'd1);
            chk("done_run", sel, 32'(done_v[sel]), 32'd0);
            chk("cout_hold_run", sel, 32'(cout_v[sel]), 32'(prev_cout[sel]));
            chk("ovf_hold_run", sel, 32'(ovf_v[sel]), 32'(prev_ovf[sel]));
            if (i > 1) begin
                mask = (32'd1 << ((i - 1) * chunk[sel])) - 32'd1;
                chk("s_partial", sel, 32'(s_v[sel]) & mask, 32'(es) & mask);
            end
            start_v[sel] = mid_start && (i == 1);
            if (start_v[sel]) scramble(sel);
            @(posedge clk);
        end
        start_v[sel] = 1'b0;
        @(negedge clk);
        chk("done_pulse", sel, 32'(done_v[sel]), 32'd1);
        chk("busy_done", sel, 32'(busy_v[sel]), 32'd0);
        chk("s", sel, 32'(s_v[sel]), 32'(es));
        chk("cout", sel, 32'(cout_v[sel]), 32'(ec));
        chk("ovf", sel, 32'(ovf_v[sel]), 32'(eo));
        prev_cout[sel] = ec;
        prev_ovf[sel]  = eo;
        if (idle_after) begin
            @(negedge clk);
            chk("done_idle", sel, 32'(done_v[sel]), 32'd0);
            chk("busy_idle", sel, 32'(busy_v[sel]), 32'd0);
            chk("s_hold", sel, 32'(s_v[sel]), 32'(es));
            chk("cout_hold", sel, 32'(cout_v[sel]), 32'(ec));
            chk("ovf_hold", sel, 32'(ovf_v[sel]), 32'(eo));
        end
    endtask

    task automatic chk_zero(input string tag, input int sel);
        chk({tag, "_s"}, sel, 32'(s_v[sel]), 32'd0);
        chk({tag, "_cout"}, sel, 32'(cout_v[sel]), 32'd0);
        chk({tag, "_ovf"}, sel, 32'(ovf_v[sel]), 32'd0);
        chk({tag, "_busy"}, sel, 32'(busy_v[sel]), 32'd0);
        chk({tag, "_done"}, sel, 32'(done_v[sel]), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0; cin_v[k] = 1'b0; sub_v[k] = 1'b0;
            prev_cout[k] = 1'b0; prev_ovf[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) chk_zero("reset", k);
        rst = 1'b0;
        @(negedge clk);

        run_op(0, 12'hFC0, 12'h03F, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("add_fff", 0, 32'(s_v[0]), 32'hFFF);
        run_op(0, 12'hFC0, 12'h03F, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("carry_chain", 0, 32'(s_v[0]), 32'h000);
        chk("carry_cout", 0, 32'(cout_v[0]), 32'd1);
        run_op(0, 12'h0E5, 12'h02B, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("b2b_sum", 0, 32'(s_v[0]), 32'h111);
        run_op(0, 12'h005, 12'h007, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("sub_neg", 0, 32'(s_v[0]), 32'hFFE);
        run_op(0, 12'h007, 12'h005, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("sub_pos", 0, 32'(s_v[0]), 32'h001);
        chk("sub_pos_cout", 0, 32'(cout_v[0]), 32'd1);
        run_op(0, 12'h7FF, 12'h001, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_add", 0, 32'(ovf_v[0]), 32'd1);
        run_op(0, 12'h800, 12'h001, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("ovf_sub_s", 0, 32'(s_v[0]), 32'h7FF);
        chk("ovf_sub", 0, 32'(ovf_v[0]), 32'd1);

        // Abort after the second RUN edge; reset acts between clock edges.
        start_v[0] = 1'b1; a_v[0] = 12'hABC; b_v[0] = 12'h321; cin_v[0] = 1'b0; sub_v[0] = 1'b0;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_zero("midrun_rst", 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            prev_cout[k] = 1'b0;
            prev_ovf[k]  = 1'b0;
        end
        run_op(0, 12'h123, 12'h456, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("after_rst", 0, 32'(s_v[0]), 32'h579);

        run_op(1, 12'hFC0, 12'h03F, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("chunk12_fff", 1, 32'(s_v[1]), 32'hFFF);
        run_op(2, 12'hFC0, 12'h03F, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("chunk1_fff", 2, 32'(s_v[2]), 32'hFFF);

        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 8; j++) begin
                run_op(k, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                       bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
